// File: rtl/comp_decomp_pkg.sv
// Shared command, response and FSM state encodings for the dictionary
// compressor/decompressor.
package comp_decomp_pkg;

  typedef enum logic [1:0] {
    CMD_NOP        = 2'b00,
    CMD_COMPRESS   = 2'b01,
    CMD_DECOMPRESS = 2'b10,
    CMD_CLEAR      = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE   = 2'b00,
    RESP_OK     = 2'b01,
    RESP_OK_NEW = 2'b10,
    RESP_ERROR  = 2'b11
  } resp_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SEARCH = 1'b1
  } state_e;

endpackage

// File: rtl/comp_decomp_engine_dict_ram.sv
// Dictionary storage: one synchronous write port, one combinational read port.
module comp_dict_ram #(
  parameter int DATA_IN_WIDTH = 80,
  parameter int DEPTH         = 256,
  parameter int AW            = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DATA_IN_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]            rd_addr,
  output logic [DATA_IN_WIDTH-1:0] rd_data
);

  logic [DATA_IN_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/comp_decomp_engine.sv
// Dictionary compressor/decompressor: sequential search on COMPRESS with a
// busy handshake, direct lookup on DECOMPRESS, count-based flush on CLEAR.
module comp_decomp_engine
  import comp_decomp_pkg::*;
#(
  parameter int DATA_IN_WIDTH = 80,
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 2**DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               command,
  input  logic [DATA_IN_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0]    compressed_in,
  output logic [DATA_WIDTH-1:0]    compressed_out,
  output logic [DATA_IN_WIDTH-1:0] decompressed_out,
  output logic [1:0]               response,
  output logic                     busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e                   state, state_n;
  logic [CW-1:0]            count, count_n;
  logic [CW-1:0]            idx, idx_n;
  logic [DATA_IN_WIDTH-1:0] key;
  logic                     load_key;
  resp_e                    resp, resp_n;
  logic [DATA_WIDTH-1:0]    cout_n;
  logic [DATA_IN_WIDTH-1:0] dout_n;
  logic                     we;
  logic [AW-1:0]            rd_addr;
  logic [DATA_IN_WIDTH-1:0] rd_data;

  // Only in-range addresses are ever acted on: idx < count in SEARCH and
  // compressed_in < count in IDLE gate every use of rd_data.
  assign rd_addr = (state == ST_SEARCH) ? idx[AW-1:0] : compressed_in[AW-1:0];

  comp_dict_ram #(
    .DATA_IN_WIDTH(DATA_IN_WIDTH),
    .DEPTH        (DEPTH),
    .AW           (AW)
  ) u_dict (
    .clk    (clk),
    .we     (we),
    .wr_addr(count[AW-1:0]),
    .wr_data(key),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  always_comb begin
    state_n  = state;
    count_n  = count;
    idx_n    = idx;
    resp_n   = RESP_NONE;
    cout_n   = compressed_out;
    dout_n   = decompressed_out;
    we       = 1'b0;
    load_key = 1'b0;
    case (state)
      ST_IDLE: begin
        case (cmd_e'(command))
          CMD_COMPRESS: begin
            load_key = 1'b1;
            idx_n    = '0;
            state_n  = ST_SEARCH;
          end
          CMD_DECOMPRESS: begin
            if (32'(compressed_in) < 32'(count)) begin
              dout_n = rd_data;
              resp_n = RESP_OK;
            end else begin
              resp_n = RESP_ERROR;
            end
          end
          CMD_CLEAR: begin
            count_n = '0;
            resp_n  = RESP_OK;
          end
          default: ;
        endcase
      end
      ST_SEARCH: begin
        if (idx == count) begin
          if (32'(count) < DEPTH) begin
            we      = 1'b1;
            cout_n  = DATA_WIDTH'(count);
            count_n = count + CW'(1);
            resp_n  = RESP_OK_NEW;
          end else begin
            resp_n = RESP_ERROR;
          end
          state_n = ST_IDLE;
        end else if (rd_data == key) begin
          cout_n  = DATA_WIDTH'(idx);
          resp_n  = RESP_OK;
          state_n = ST_IDLE;
        end else begin
          idx_n = idx + CW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      count            <= '0;
      idx              <= '0;
      resp             <= RESP_NONE;
      compressed_out   <= '0;
      decompressed_out <= '0;
    end else begin
      state            <= state_n;
      count            <= count_n;
      idx              <= idx_n;
      resp             <= resp_n;
      compressed_out   <= cout_n;
      decompressed_out <= dout_n;
    end
  end

  // The search key is pure data and needs no reset.
  always_ff @(posedge clk) begin
    if (load_key) key <= data_in;
  end

  assign response = resp;
  assign busy     = (state == ST_SEARCH);

endmodule

// File: tb/tb_comp_decomp_engine.sv
// Scoreboard bench for comp_decomp_engine with DEPTH=4.
module tb_comp_decomp_engine;

  localparam int DIW   = 80;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [1:0]     command = 2'b00;
  logic [DIW-1:0] data_in = '0;
  logic [DW-1:0]  compressed_in = '0;
  logic [DW-1:0]  compressed_out;
  logic [DIW-1:0] decompressed_out;
  logic [1:0]     response;
  logic           busy;

  comp_decomp_engine #(
    .DATA_IN_WIDTH(DIW),
    .DATA_WIDTH   (DW),
    .DEPTH        (DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .command         (command),
    .data_in         (data_in),
    .compressed_in   (compressed_in),
    .compressed_out  (compressed_out),
    .decompressed_out(decompressed_out),
    .response        (response),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]     resp;
    int             lat;
    int             acc;
    logic [DW-1:0]  cout;
    logic [DIW-1:0] dout;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   edge_n   = 0;

  logic [DIW-1:0] mdict [DEPTH];
  int             mcount = 0;
  logic [DW-1:0]  m_cout = '0;
  logic [DIW-1:0] m_dout = '0;

  localparam logic [DIW-1:0] WA = 80'h0123_4567_89AB_CDEF_0011;
  localparam logic [DIW-1:0] WB = 80'hDEAD_BEEF_CAFE_F00D_2222;
  localparam logic [DIW-1:0] WC = 80'h5555_AAAA_5555_AAAA_3333;
  localparam logic [DIW-1:0] WD = 80'hFFFF_0000_FFFF_0000_4444;
  localparam logic [DIW-1:0] WE = 80'h8000_0000_0000_0000_0001;

  task automatic check(input string tag, input logic [DIW-1:0] act, input logic [DIW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Response monitor: sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    edge_n++;
    #1;
    if (response != 2'b00) begin
      if (sb.size() == 0) begin
        check("spurious_resp", DIW'(response), '0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp", DIW'(response), DIW'(e.resp));
        check("latency", DIW'(edge_n - e.acc + 1), DIW'(e.lat));
        check("compressed_out", DIW'(compressed_out), DIW'(e.cout));
        check("decompressed_out", decompressed_out, e.dout);
      end
    end
  end

  function automatic exp_t predict(input logic [1:0] cmd, input logic [DIW-1:0] d,
                                   input logic [DW-1:0] code);
    exp_t e;
    int   hit;
    e.resp = 2'b00;
    e.lat  = 1;
    e.acc  = 0;
    if (cmd == 2'b01) begin
      hit = -1;
      for (int i = 0; i < mcount; i++)
        if (hit < 0 && mdict[i] == d) hit = i;
      if (hit >= 0) begin
        e.resp = 2'b01; e.lat = hit + 2; m_cout = DW'(hit);
      end else if (mcount < DEPTH) begin
        e.resp = 2'b10; e.lat = mcount + 2; m_cout = DW'(mcount);
        mdict[mcount] = d; mcount++;
      end else begin
        e.resp = 2'b11; e.lat = DEPTH + 2;
      end
    end else if (cmd == 2'b10) begin
      if (int'(code) < mcount) begin
        e.resp = 2'b01; m_dout = mdict[code];
      end else begin
        e.resp = 2'b11;
      end
    end else if (cmd == 2'b11) begin
      e.resp = 2'b01; mcount = 0;
    end
    e.cout = m_cout;
    e.dout = m_dout;
    return e;
  endfunction

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("timeout_pending", DIW'(sb.size()), '0);
    sb.delete();
  endtask

  task automatic send(input logic [1:0] cmd, input logic [DIW-1:0] d, input logic [DW-1:0] code);
    exp_t e;
    @(negedge clk);
    command = cmd; data_in = d; compressed_in = code;
    e = predict(cmd, d, code);
    e.acc = edge_n + 1;
    sb.push_back(e);
    @(negedge clk);
    command = 2'b00;
    wait_done();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_cout", DIW'(compressed_out), '0);
      check("rst_dout", decompressed_out, '0);
      check("rst_resp", DIW'(response), '0);
      check("rst_busy", DIW'(busy), '0);
    end

    send(2'b01, WA, '0);
    send(2'b01, WB, '0);
    send(2'b01, WA, '0);
    check("a_code", DIW'(compressed_out), '0);

    send(2'b10, '0, 8'd1);
    check("dec1_word", decompressed_out, WB);
    send(2'b10, '0, 8'd3);
    send(2'b10, '0, 8'd200);

    send(2'b01, WC, '0);
    send(2'b01, WD, '0);
    send(2'b01, WE, '0);
    check("overflow_cout", DIW'(compressed_out), DIW'(3));
    send(2'b10, '0, 8'd3);
    check("full_dec3", decompressed_out, WD);

    send(2'b11, '0, '0);
    send(2'b10, '0, 8'd0);
    send(2'b01, WB, '0);
    check("reuse_code", DIW'(compressed_out), '0);

    // Three entries, then abort a miss search with reset.
    send(2'b01, WC, '0);
    send(2'b01, WD, '0);
    @(negedge clk);
    command = 2'b01; data_in = WE;
    @(negedge clk);
    command = 2'b00;
    check("busy_in_search", DIW'(busy), DIW'(1));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mcount = 0; m_cout = '0; m_dout = '0;
    check("abort_busy", DIW'(busy), '0);
    check("abort_cout", DIW'(compressed_out), '0);
    repeat (4) @(negedge clk);
    send(2'b10, '0, 8'd0);

    // DECOMPRESS presented while busy must be ignored.
    send(2'b01, WA, '0);
    send(2'b01, WB, '0);
    send(2'b01, WC, '0);
    begin
      exp_t e;
      @(negedge clk);
      command = 2'b01; data_in = WD;
      e = predict(2'b01, WD, '0);
      e.acc = edge_n + 1;
      sb.push_back(e);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        command = 2'b10; compressed_in = 8'd0;
      end
      @(negedge clk);
      command = 2'b00;
      wait_done();
    end
    check("ignored_dout", decompressed_out, '0);
    check("busy_code", DIW'(compressed_out), DIW'(3));
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/comp_decomp_engine.md
# comp_decomp_engine

Parametrised dictionary compressor/decompressor behind the `comp_if` pin set; the next generation of the fixed 80-bit/8-bit comp/decomp DUT. `COMPRESS` maps a wide data word to a short code, allocating a new dictionary entry on a miss. `DECOMPRESS` maps a code back to its word. `CLEAR` flushes the dictionary. It adds a configurable width and depth, a sequential search with a `busy` handshake, and full/invalid-code error reporting. It is the RTL DUT checked against the SystemC reference model by the UVM bench.

## Interface
Parameters:
- `DATA_IN_WIDTH`, 80: uncompressed word width.
- `DATA_WIDTH`, 8: code width.
- `DEPTH`, 2**DATA_WIDTH: dictionary entries. Must satisfy 1 ≤ DEPTH ≤ 2**DATA_WIDTH.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `command` in 2: 00 NOP, 01 COMPRESS, 10 DECOMPRESS, 11 CLEAR.
- `data_in` in DATA_IN_WIDTH: word to compress.
- `compressed_in` in DATA_WIDTH: code to decompress.
- `compressed_out` out DATA_WIDTH: code result.
- `decompressed_out` out DATA_IN_WIDTH: word result.
- `response` out 2: 00 NONE, 01 OK, 10 OK_NEW, 11 ERROR.
- `busy` out 1: high while a compress search is in progress.

## Operation
- **State:** dictionary `dict[DEPTH]`; `count` of width $clog2(DEPTH+1); FSM IDLE/SEARCH; search index `idx`; latched word `key`.
- **Accept:** a command is accepted at a rising edge when `busy`=0 and `command`≠NOP. Commands presented while `busy`=1 are ignored; there is no queuing.
- **DECOMPRESS** (decided at the accept edge):
  - `compressed_in` < `count`: `decompressed_out`←`dict[compressed_in]`, `response`=OK.
  - Otherwise: `response`=ERROR and `decompressed_out` is unchanged.
- **CLEAR:** `count`←0, `response`=OK. Dictionary contents are not erased; validity is tracked by `count` only.
- **COMPRESS:** `key`←`data_in`, `idx`←0, go to SEARCH. Each SEARCH edge:
  - `idx`==`count` (miss):
    - If `count`<DEPTH: `dict[count]`←`key`, `compressed_out`←`count`, `count`++, `response`=OK_NEW.
    - Else: `response`=ERROR, `compressed_out` unchanged.
    - Go to IDLE.
  - Else if `dict[idx]`==`key` (hit): `compressed_out`←`idx`, `response`=OK, go to IDLE.
  - Otherwise `idx`++.
- **Code ordering:** the lowest matching index wins. Duplicate entries cannot arise, because insertion only happens on a miss.
- **Result outputs:** `compressed_out` and `decompressed_out` hold their last written value until overwritten.
- **Arithmetic:** `compressed_out` is `count`/`idx` truncated to DATA_WIDTH, which is lossless given the DEPTH constraint. The `compressed_in` comparison is unsigned.

## Timing
- **Reset values:** all outputs 0, `count`=0, FSM=IDLE.
- **Reset asserted mid-search:** aborts the search with no response; the dictionary is empty afterwards.
- **`response` pulse:** registered; non-NONE for exactly one cycle, the cycle after the deciding edge, and NONE otherwise. Result outputs update on the same edge.
- **Latency,** counted from the accept edge to the response cycle:
  - DECOMPRESS / CLEAR: 1 cycle.
  - COMPRESS hit at index i: i+2 cycles.
  - COMPRESS miss with n entries: n+2 cycles.
- **`busy`:** equals (FSM==SEARCH). It rises the cycle after a COMPRESS accept and falls in the response cycle. A new command may therefore be accepted in the response cycle, giving back-to-back operation.
- **Visibility of new entries:** an entry inserted on edge E is visible to a command accepted at E+1 or later.
- **Exhaustive miss:** worst-case COMPRESS latency is DEPTH+2 cycles; a full dictionary still searches all entries before reporting ERROR.

## Structure
- **Package `comp_decomp_pkg`:**
  - `cmd_e` (NOP/COMPRESS/DECOMPRESS/CLEAR)
  - `resp_e` (NONE/OK/OK_NEW/ERROR)
  - `state_e` (IDLE/SEARCH)
- **Sub-module `comp_dict_ram`:** DEPTH×DATA_IN_WIDTH storage with one synchronous write port and one combinational read port. The read address is muxed: `idx` in SEARCH, `compressed_in` in IDLE.
- **Top:** holds the FSM, `count`, `idx`, `key` and the output registers.

## Test plan
All scenarios use DEPTH=4, DATA_WIDTH=8, DATA_IN_WIDTH=80.
- **Reset then NOP:** all outputs 0, `busy`=0, `response`=NONE every cycle.
- **COMPRESS A, B, A:** first A gives OK_NEW with code 0 (latency 2). B gives OK_NEW with code 1 (latency 3). Second A gives OK with code 0 (latency 2).
- **Decompress codes 1 and 3 after the previous scenario:**
  - DECOMPRESS 1: `decompressed_out`=B, OK, latency 1.
  - DECOMPRESS 3: ERROR, `decompressed_out` still B.
- **Fill and overflow:** COMPRESS 4 distinct words gives codes 0..3. A 5th distinct word gives ERROR after 6 cycles, `count` stays 4, and `compressed_out` stays 3.
- **CLEAR then reuse:** CLEAR gives OK. DECOMPRESS 0 then gives ERROR. COMPRESS B then gives OK_NEW with code 0.
- **Reset mid-search and busy handling:**
  - With 3 entries, start COMPRESS of a new word and assert `reset` 2 cycles later. No response appears, and DECOMPRESS 0 afterwards gives ERROR.
  - A separate run drives DECOMPRESS while `busy`=1; it is ignored.
